// File: rtl/reg_alu_sequencer_if.sv
// Request handshake, register-file port and completion report for reg_alu_sequencer.
// slave is the sequencer's view; master is the upstream/register-file side.
interface reg_alu_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_op;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic [ADDR_WIDTH-1:0] in_rs1;
  logic [ADDR_WIDTH-1:0] in_rs2;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  done;
  logic [DATA_WIDTH-1:0] done_result;
  logic [2:0]            done_flag;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, rdata1, rdata2,
    output in_ready, raddr1, raddr2, wen, waddr, wdata, done, done_result, done_flag
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, rdata1, rdata2,
    input  in_ready, raddr1, raddr2, wen, waddr, wdata, done, done_result, done_flag
  );
endinterface

// File: rtl/reg_alu_sequencer.sv
// Four-state execute controller: accept, read operands, compute ALU result/flags,
// write back to the register file and pulse done with the result.
module reg_alu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic                clk,
  input logic                rst,
  reg_alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_t;

  state_t                state, state_next;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0] result_q, last_result_q;
  logic [2:0]            flag_q, last_flag_q;

  logic                  accept;
  logic [DATA_WIDTH:0]   sum_ext, diff_ext;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_ovf, alu_carry, alu_known;
  logic [2:0]            alu_flag;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = READ;
      READ: state_next = EXEC;
      EXEC: state_next = WB;
      WB:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The borrow of A-B is the extra top bit of the widened difference.
  assign sum_ext  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_ext = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    alu_carry  = 1'b0;
    alu_known  = 1'b1;
    case (op_q)
      OP_AND: alu_result = a_q & b_q;
      OP_OR:  alu_result = a_q | b_q;
      OP_ADD: begin
        alu_result = sum_ext[DATA_WIDTH-1:0];
        alu_carry  = sum_ext[DATA_WIDTH];
        alu_ovf    = (a_q[DATA_WIDTH-1] == b_q[DATA_WIDTH-1]) &&
                     (sum_ext[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        alu_result = diff_ext[DATA_WIDTH-1:0];
        alu_carry  = diff_ext[DATA_WIDTH];
        alu_ovf    = (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &&
                     (diff_ext[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
      end
      OP_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_known = 1'b0;
    endcase
    alu_flag = alu_known ? {alu_ovf, alu_carry, (alu_result == '0)} : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      result_q      <= '0;
      flag_q        <= '0;
      last_result_q <= '0;
      last_flag_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (accept) begin
        op_q  <= bus.in_op;
        rd_q  <= bus.in_rd;
        rs1_q <= bus.in_rs1;
        rs2_q <= bus.in_rs2;
      end
      if (state == READ) begin
        a_q <= bus.rdata1;
        b_q <= bus.rdata2;
      end
      if (state == EXEC) begin
        result_q <= alu_result;
        flag_q   <= alu_flag;
      end
      if (state == WB) begin
        last_result_q <= result_q;
        last_flag_q   <= flag_q;
      end
    end
  end

  // A reset arriving in WB suppresses the write and the done pulse in that same cycle.
  assign bus.in_ready    = (state == IDLE);
  assign bus.raddr1      = (state == READ) ? rs1_q : '0;
  assign bus.raddr2      = (state == READ) ? rs2_q : '0;
  assign bus.done        = (state == WB) && !rst;
  assign bus.wen         = bus.done && (rd_q != '0);
  assign bus.waddr       = (state == WB) ? rd_q : '0;
  assign bus.wdata       = (state == WB) ? result_q : '0;
  assign bus.done_result = bus.done ? result_q : last_result_q;
  assign bus.done_flag   = bus.done ? flag_q : last_flag_q;

endmodule
